// File: rtl/boot_run_ctrl.sv
// Boot-and-run controller: streams IM/DM images over a valid/ready port while
// holding the CPU in reset, then runs it until halt or cycle budget expiry.
module boot_run_ctrl #(
    parameter int DATA_W = 32,
    parameter int IM_AW  = 10,
    parameter int DM_AW  = 10,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_dm_en,
    input  logic [CNT_W-1:0]  run_budget,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              cpu_halt,
    output logic              im_we,
    output logic [IM_AW-1:0]  im_addr,
    output logic              dm_we,
    output logic [DM_AW-1:0]  dm_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              trunc,
    output logic [CNT_W-1:0]  cycles
);

    typedef enum logic [2:0] {IDLE, LOAD_IM, LOAD_DM, RUN, DONE} state_t;

    state_t             state;
    logic [IM_AW-1:0]   im_cnt;
    logic [DM_AW-1:0]   dm_cnt;
    logic               dm_en_q;
    logic [CNT_W-1:0]   budget_q;
    logic               accept;
    logic               budget_exit;

    assign accept      = ld_valid && ld_ready;
    // budget_q is never zero, so budget_q-1 cannot underflow
    assign budget_exit = (cycles == budget_q - CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            im_cnt    <= '0;
            dm_cnt    <= '0;
            dm_en_q   <= 1'b0;
            budget_q  <= CNT_W'(1);
            ld_ready  <= 1'b0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            mem_wdata <= '0;
            cpu_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            trunc     <= 1'b0;
            cycles    <= '0;
        end else begin
            im_we <= 1'b0;
            dm_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= LOAD_IM;
                        ld_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        timeout  <= 1'b0;
                        trunc    <= 1'b0;
                        cycles   <= '0;
                        im_cnt   <= '0;
                        dm_cnt   <= '0;
                        dm_en_q  <= load_dm_en;
                        budget_q <= (run_budget == '0) ? CNT_W'(1) : run_budget;
                    end
                end
                LOAD_IM: begin
                    if (accept) begin
                        im_we     <= 1'b1;
                        im_addr   <= im_cnt;
                        mem_wdata <= ld_data;
                        im_cnt    <= im_cnt + IM_AW'(1);
                        if (ld_last || im_cnt == '1) begin
                            if (!ld_last) trunc <= 1'b1;
                            if (dm_en_q) begin
                                state <= LOAD_DM;
                            end else begin
                                state    <= RUN;
                                ld_ready <= 1'b0;
                                cpu_rst  <= 1'b0;
                            end
                        end
                    end
                end
                LOAD_DM: begin
                    if (accept) begin
                        dm_we     <= 1'b1;
                        dm_addr   <= dm_cnt;
                        mem_wdata <= ld_data;
                        dm_cnt    <= dm_cnt + DM_AW'(1);
                        if (ld_last || dm_cnt == '1) begin
                            if (!ld_last) trunc <= 1'b1;
                            state    <= RUN;
                            ld_ready <= 1'b0;
                            cpu_rst  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    // halt takes priority over budget expiry, so timeout only on budget-only exit
                    if (cpu_halt || budget_exit) begin
                        state   <= DONE;
                        timeout <= !cpu_halt;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cpu_rst <= 1'b1;
                    end else if (cycles != '1) begin
                        cycles <= cycles + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
